mbist_response_analyzer: RTL and testbench
==========================================

MBIST_RESPONSE_ANALYZER -- requirements
Module: mbist_response_analyzer

Interface
REQ-001 The block SHALL have these parameters:
- CAWIDTH, default 4: column-address width.
- DWIDTH, default 8: data width.
- LOGDEPTH, default 4: fail-log entries; a power of two, 2 or more.
- CNTWIDTH, default 8: fail-counter width.

REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- test_start  in  1  one-cycle pulse that starts or restarts a session.
- cmp_valid  in  1  a compare sample is present this cycle.
- cmp_addr  in  CAWIDTH  address of the sample.
- cmp_expected  in  DWIDTH  expected read data.
- cmp_actual  in  DWIDTH  memory read data.
- cmp_element  in  2  March element index, 0 to 3.
- test_done  in  1  pulse: the controller has issued its last sample.
- log_ready  in  1  consumer accepts a log entry.
- log_valid  out  1  log entry present.
- log_addr  out  CAWIDTH  failing address.
- log_syndrome  out  DWIDTH  expected XOR actual.
- log_element  out  2  failing element.
- fail_count  out  CNTWIDTH  number of mismatches.
- status  out  1  sticky fail flag.
- log_overflow  out  1  sticky: a fail entry was dropped.
- done  out  1  session complete and log drained.

Function
REQ-003 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-004 Transitions SHALL be:
- IDLE to RUN on test_start.
- RUN to DRAIN on test_done.
- DRAIN to DONE when the log is empty.
- DONE to RUN on test_start.
REQ-005 test_start in any state SHALL clear fail_count, status, log_overflow and the log, and enter RUN on the next cycle.
REQ-006 test_start SHALL have priority over test_done in the same cycle.
REQ-007 cmp_valid SHALL be ignored outside RUN.
REQ-008 A sample with cmp_valid and test_done in the same cycle SHALL be evaluated, then the FSM SHALL enter DRAIN.
REQ-009 A mismatch SHALL be defined as cmp_valid high in RUN with (cmp_expected XOR cmp_actual) not equal to 0.
REQ-010 On a mismatch at edge N:
- status SHALL be 1 after edge N (one-cycle latency) and SHALL stay 1 until the next clear.
- fail_count SHALL increment by 1 at edge N, saturating at all-ones.
REQ-011 On a mismatch, the entry {cmp_addr, syndrome, cmp_element} SHALL be pushed into a LOGDEPTH-entry FIFO.
REQ-012 The FIFO SHALL be show-ahead:
- log_valid equals FIFO not empty.
- A pop occurs when log_valid and log_ready are both 1.
- log_* outputs show the oldest entry.
REQ-013 A push into an empty FIFO SHALL become visible on log_valid on the cycle after the push; there is no bypass.
REQ-014 A push when the FIFO is full and no pop occurs that cycle SHALL drop the entry and set log_overflow; fail_count still increments.
REQ-015 A push when the FIFO is full with a simultaneous pop SHALL be accepted, with no overflow.
REQ-016 The FIFO read and write pointers SHALL wrap modulo LOGDEPTH, using an extra pointer bit to tell full from empty.
REQ-017 done SHALL be 1 only in the DONE state.
REQ-018 Popping SHALL remain legal in every state.

Reset
REQ-019 rst low SHALL asynchronously force:
- state = IDLE;
- FIFO empty;
- log_valid = 0 and log_addr, log_syndrome, log_element = 0;
- fail_count = 0, status = 0, log_overflow = 0, done = 0.
REQ-020 rst asserted mid-session SHALL discard all logged entries.
REQ-021 The first active edge after rst is released SHALL see state IDLE.

Configuration
REQ-022 When MBIST_FAIL_LOG_EN is defined, the FIFO and all log_* and log_overflow behaviour SHALL be present as specified above.
REQ-023 When MBIST_FAIL_LOG_EN is undefined:
- No FIFO storage SHALL be instantiated.
- log_valid, log_addr, log_syndrome, log_element and log_overflow SHALL be constant 0.
- DRAIN SHALL pass to DONE on the next cycle.
- fail_count, status and done SHALL behave unchanged.

Verification
REQ-024 Clean pass: start; 16 samples with expected = actual = 0x00; test_done.
Required: status = 0, fail_count = 0, log_valid never 1, done = 1 two cycles after test_done.

REQ-025 Single fail: sample at addr 0x5 with exp 0xFF, act 0xF7, element 1; log_ready = 1.
Required: status = 1 on the next cycle; log entry {0x5, 0x08, 1}; fail_count = 1.

REQ-026 Overflow: 6 consecutive mismatches at addrs 0 to 5, log_ready = 0.
Required: fail_count = 6; log_overflow = 1; the log holds addrs 0 to 3 in order.

REQ-027 Full FIFO with push and pop: FIFO full, then a mismatch in the same cycle as log_ready = 1.
Required: no overflow; entry count stays 4.

REQ-028 Reset mid-session: rst low during RUN with 2 entries logged.
Required: all outputs 0 immediately; state IDLE; after release, samples are ignored until test_start.

REQ-029 Macro off: repeat REQ-026 without MBIST_FAIL_LOG_EN.
Required: fail_count = 6, status = 1, log_valid = 0, log_overflow = 0.

Source files
------------

// File: rtl/mbist_response_analyzer.sv
// MBIST response analyzer: compares memory read data against expected data, counts mismatches and logs failing entries.
// Latency: status and fail_count update on the edge that samples a mismatch; log entries appear on log_valid one cycle after the push.
// Backpressure: log_ready pops the show-ahead fail log; when the log is full, entries are dropped and log_overflow is set. Define MBIST_FAIL_LOG_EN to build the log.
module mbist_response_analyzer #(
    parameter int CAWIDTH  = 4,
    parameter int DWIDTH   = 8,
    parameter int LOGDEPTH = 4,
    parameter int CNTWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                test_start,
    input  logic                cmp_valid,
    input  logic [CAWIDTH-1:0]  cmp_addr,
    input  logic [DWIDTH-1:0]   cmp_expected,
    input  logic [DWIDTH-1:0]   cmp_actual,
    input  logic [1:0]          cmp_element,
    input  logic                test_done,
    input  logic                log_ready,
    output logic                log_valid,
    output logic [CAWIDTH-1:0]  log_addr,
    output logic [DWIDTH-1:0]   log_syndrome,
    output logic [1:0]          log_element,
    output logic [CNTWIDTH-1:0] fail_count,
    output logic                status,
    output logic                log_overflow,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNTWIDTH-1:0]   r_fail_count;
    logic                  r_status;
    logic [DWIDTH-1:0]     w_syndrome;
    logic                  w_mismatch;
    logic                  w_log_empty;

    // A restart in the same cycle wins over any sample, so the sample is discarded.
    assign w_syndrome = cmp_expected ^ cmp_actual;
    assign w_mismatch = (r_state == RUN) && cmp_valid && !test_start && (w_syndrome != '0);

    // Next-state logic; test_start restarts from any state and beats test_done.
    always_comb begin
        w_state_nxt = r_state;
        if (test_start) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN:     if (test_done) w_state_nxt = DRAIN;
                DRAIN:   if (w_log_empty) w_state_nxt = DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Saturating fail counter and sticky fail flag, cleared on session start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fail_count <= '0;
            r_status     <= 1'b0;
        end else if (test_start) begin
            r_fail_count <= '0;
            r_status     <= 1'b0;
        end else if (w_mismatch) begin
            r_status <= 1'b1;
            if (r_fail_count != '1) r_fail_count <= r_fail_count + CNTWIDTH'(1);
        end
    end

    assign fail_count = r_fail_count;
    assign status     = r_status;
    assign done       = (r_state == DONE);

`ifdef MBIST_FAIL_LOG_EN
    localparam int PW = $clog2(LOGDEPTH);

    typedef struct packed {
        logic [CAWIDTH-1:0] addr;
        logic [DWIDTH-1:0]  syndrome;
        logic [1:0]         element;
    } log_entry_t;

    log_entry_t  r_mem [LOGDEPTH];
    log_entry_t  w_wr_entry;
    log_entry_t  w_head;
    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    logic        r_overflow;
    logic        w_full;
    logic        w_pop;
    logic        w_push_ok;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
    assign w_log_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_pop       = !w_log_empty && log_ready;
    assign w_push_ok   = w_mismatch && (!w_full || w_pop);
    assign w_wr_entry  = '{addr: cmp_addr, syndrome: w_syndrome, element: cmp_element};

    // Log pointers and sticky overflow; a full log with a same-cycle pop still accepts the push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (test_start) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
            if (w_mismatch && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // Entry storage; contents are only observed through a valid read pointer.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[PW-1:0]] <= w_wr_entry;
    end

    // Show-ahead head, forced to zero when empty so reset and idle outputs are clean.
    assign w_head       = w_log_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];
    assign log_valid    = !w_log_empty;
    assign log_addr     = w_head.addr;
    assign log_syndrome = w_head.syndrome;
    assign log_element  = w_head.element;
    assign log_overflow = r_overflow;
`else
    logic w_unused_log_ins;

    // Without the log there is nothing to drain and the log inputs are don't-care.
    assign w_log_empty      = 1'b1;
    assign w_unused_log_ins = ^{log_ready, cmp_addr, cmp_element};
    assign log_valid        = 1'b0;
    assign log_addr         = '0;
    assign log_syndrome     = '0;
    assign log_element      = '0;
    assign log_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_mbist_response_analyzer.sv
// Bench for mbist_response_analyzer: directed sessions; log entries are checked by a scoreboard monitor.
// Expectations follow the build: with MBIST_FAIL_LOG_EN the log is modelled, otherwise log outputs stay 0.
// The bench drives log_ready itself and bounds every wait.
module tb_mbist_response_analyzer;

`ifdef MBIST_FAIL_LOG_EN
    localparam logic LOG = 1'b1;
`else
    localparam logic LOG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       test_start, cmp_valid, test_done, log_ready;
    logic [3:0] cmp_addr;
    logic [7:0] cmp_expected, cmp_actual;
    logic [1:0] cmp_element;
    logic       log_valid, status, log_overflow, done;
    logic [3:0] log_addr;
    logic [7:0] log_syndrome;
    logic [1:0] log_element;
    logic [7:0] fail_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [13:0] sb[$];

    mbist_response_analyzer dut (
        .clk(clk), .rst(rst), .test_start(test_start), .cmp_valid(cmp_valid),
        .cmp_addr(cmp_addr), .cmp_expected(cmp_expected), .cmp_actual(cmp_actual),
        .cmp_element(cmp_element), .test_done(test_done), .log_ready(log_ready),
        .log_valid(log_valid), .log_addr(log_addr), .log_syndrome(log_syndrome),
        .log_element(log_element), .fail_count(fail_count), .status(status),
        .log_overflow(log_overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted log entry must match the oldest expected one.
    always @(negedge clk) begin
        logic [13:0] e;
        if (rst && log_valid && log_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL log_unexpected: got entry 0x%0h, required none", {log_addr, log_syndrome, log_element});
            end else begin
                e = sb.pop_front();
                chk("log_entry", 32'({log_addr, log_syndrome, log_element}), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmp(input logic [3:0] a, input logic [7:0] e, input logic [7:0] x, input logic [1:0] el);
        cmp_valid = 1'b1; cmp_addr = a; cmp_expected = e; cmp_actual = x; cmp_element = el;
    endtask

    task automatic idle_cmp();
        cmp_valid = 1'b0; cmp_addr = '0; cmp_expected = '0; cmp_actual = '0; cmp_element = '0;
    endtask

    task automatic expect_entry(input logic [3:0] a, input logic [7:0] syn, input logic [1:0] el);
        if (LOG) sb.push_back({a, syn, el});
    endtask

    task automatic start_session();
        log_ready  = 1'b0;
        test_start = 1'b1;
        sb.delete();
        step();
        test_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        chk("done_reached", 32'(done), 32'(1));
    endtask

    initial begin
        rst = 1'b0; test_start = 1'b0; test_done = 1'b0; log_ready = 1'b0;
        idle_cmp();

        // Reset state
        #2;
        chk("rst_fail_count", 32'(fail_count), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_log_valid", 32'(log_valid), 0);
        chk("rst_overflow", 32'(log_overflow), 0);
        chk("rst_done", 32'(done), 0);
        #10 rst = 1'b1;
        step();

        // Clean pass: 16 matching samples
        start_session();
        log_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_cmp(4'(i), 8'h00, 8'h00, 2'(i));
            step();
        end
        idle_cmp();
        test_done = 1'b1;
        step();
        test_done = 1'b0;
        chk("pass_done_c1", 32'(done), 0);
        step();
        chk("pass_done_c2", 32'(done), 1);
        chk("pass_status", 32'(status), 0);
        chk("pass_count", 32'(fail_count), 0);

        // Single fail, no bypass into the log
        start_session();
        log_ready = 1'b1;
        drive_cmp(4'h5, 8'hFF, 8'hF7, 2'd1);
        expect_entry(4'h5, 8'h08, 2'd1);
        chk("single_no_bypass", 32'(log_valid), 0);
        step();
        idle_cmp();
        chk("single_status", 32'(status), 1);
        chk("single_count", 32'(fail_count), 1);
        chk("single_log_valid", 32'(log_valid), 32'(LOG));
        step();
        step();
        chk("single_drained", 32'(sb.size()), 0);

        // Overflow: 6 mismatches with log_ready low
        start_session();
        for (int i = 0; i < 6; i++) begin
            drive_cmp(4'(i), 8'h00, 8'(i + 1), 2'(i));
            if (i < 4) expect_entry(4'(i), 8'(i + 1), 2'(i));
            step();
        end
        idle_cmp();
        chk("ovf_count", 32'(fail_count), 6);
        chk("ovf_flag", 32'(log_overflow), 32'(LOG));
        chk("ovf_status", 32'(status), 1);
        chk("ovf_log_valid", 32'(log_valid), 32'(LOG));
        log_ready = 1'b1;
        repeat (6) step();
        log_ready = 1'b0;
        chk("ovf_drained", 32'(sb.size()), 0);
        chk("ovf_empty", 32'(log_valid), 0);

        // Full log with simultaneous push and pop
        start_session();
        for (int i = 0; i < 4; i++) begin
            drive_cmp(4'(i), 8'h3C, 8'h3C ^ (8'h01 << i), 2'(3 - i));
            expect_entry(4'(i), 8'h01 << i, 2'(3 - i));
            step();
        end
        idle_cmp();
        chk("full_no_ovf", 32'(log_overflow), 0);
        drive_cmp(4'h9, 8'hAA, 8'hFF, 2'd2);
        expect_entry(4'h9, 8'h55, 2'd2);
        log_ready = 1'b1;
        step();
        idle_cmp();
        log_ready = 1'b0;
        chk("pushpop_ovf", 32'(log_overflow), 0);
        chk("pushpop_count", 32'(fail_count), 5);
        log_ready = 1'b1;
        repeat (3) step();
        chk("pushpop_fourth_left", 32'(log_valid), 32'(LOG));
        step();
        chk("pushpop_empty", 32'(log_valid), 0);
        chk("pushpop_drained", 32'(sb.size()), 0);

        // Counter saturation with the log streaming out
        start_session();
        log_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            drive_cmp(4'(i), 8'h01, 8'h00, 2'd0);
            expect_entry(4'(i), 8'h01, 2'd0);
            step();
        end
        idle_cmp();
        step();
        step();
        chk("sat_count", 32'(fail_count), 255);
        chk("sat_ovf", 32'(log_overflow), 0);
        chk("sat_drained", 32'(sb.size()), 0);

        // Reset mid-session with two entries logged
        start_session();
        drive_cmp(4'hA, 8'h00, 8'h11, 2'd0); step();
        drive_cmp(4'hB, 8'h00, 8'h22, 2'd1); step();
        idle_cmp();
        chk("prerst_log_valid", 32'(log_valid), 32'(LOG));
        #2 rst = 1'b0;
        #1;
        chk("mrst_log_valid", 32'(log_valid), 0);
        chk("mrst_log_addr", 32'(log_addr), 0);
        chk("mrst_log_syndrome", 32'(log_syndrome), 0);
        chk("mrst_log_element", 32'(log_element), 0);
        chk("mrst_count", 32'(fail_count), 0);
        chk("mrst_status", 32'(status), 0);
        chk("mrst_overflow", 32'(log_overflow), 0);
        chk("mrst_done", 32'(done), 0);
        #3 rst = 1'b1;
        step();
        log_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cmp(4'(i), 8'hFF, 8'h00, 2'd0);
            step();
        end
        idle_cmp();
        chk("idle_ign_count", 32'(fail_count), 0);
        chk("idle_ign_status", 32'(status), 0);
        chk("idle_ign_log_valid", 32'(log_valid), 0);
        chk("idle_ign_done", 32'(done), 0);

        // test_start beats test_done; sample with test_done is still evaluated
        test_start = 1'b1; test_done = 1'b1;
        sb.delete();
        step();
        test_start = 1'b0; test_done = 1'b0;
        drive_cmp(4'h3, 8'hF0, 8'h00, 2'd2);
        expect_entry(4'h3, 8'hF0, 2'd2);
        step();
        chk("prio_run_count", 32'(fail_count), 1);
        drive_cmp(4'h4, 8'h0F, 8'h0E, 2'd3);
        expect_entry(4'h4, 8'h01, 2'd3);
        test_done = 1'b1;
        step();
        idle_cmp();
        test_done = 1'b0;
        chk("lastsample_count", 32'(fail_count), 2);
        chk("drain_not_done", 32'(done), 0);
        wait_done(10);
        chk("final_drained", 32'(sb.size()), 0);

        // Samples in DONE are ignored
        drive_cmp(4'h1, 8'hFF, 8'h00, 2'd0);
        step();
        idle_cmp();
        chk("done_ign_count", 32'(fail_count), 2);
        chk("done_stays", 32'(done), 1);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
